// File: rtl/ddr_axi_master.sv
// ddr_axi_master
//   Bridges the data cache's line writeback and line refill requests onto the
//   DDR controller's AXI4 slave port. Each request becomes one single-beat
//   128-bit burst. The read and write engines are independent, so one read
//   and one write can be in flight at the same time.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   wr_addr/wr_data/wr_valid/wr_ready line writeback request; wr_ready rising
//                                     again signals that the write completed
//   rd_addr/rd_avalid/rd_aready       line refill request
//   rd_data/rd_valid/rd_dready        refill data, held until taken
//   M_AXI_AW*/W*/B*                   AXI4 write address/data/response
//   M_AXI_AR*/R*                      AXI4 read address/data
//
// Build option
//   AXI_AW_W_CONCURRENT_EN: issue AW and W together in one state. Each VALID
//   drops on its own handshake. Without the macro, W waits for the AW
//   handshake to finish.
module ddr_axi_master (
  input  logic         clk,
  input  logic         rst,
  input  logic [26:0]  wr_addr,
  input  logic [127:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [26:0]  rd_addr,
  input  logic         rd_avalid,
  output logic         rd_aready,
  output logic [127:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_dready,
  output logic [26:0]  M_AXI_AWADDR,
  output logic [7:0]   M_AXI_AWLEN,
  output logic [2:0]   M_AXI_AWSIZE,
  output logic [1:0]   M_AXI_AWBURST,
  output logic         M_AXI_AWLOCK,
  output logic [3:0]   M_AXI_AWCACHE,
  output logic [2:0]   M_AXI_AWPROT,
  output logic [3:0]   M_AXI_AWQOS,
  output logic         M_AXI_AWVALID,
  input  logic         M_AXI_AWREADY,
  output logic [127:0] M_AXI_WDATA,
  output logic [15:0]  M_AXI_WSTRB,
  output logic         M_AXI_WLAST,
  output logic         M_AXI_WVALID,
  input  logic         M_AXI_WREADY,
  input  logic [1:0]   M_AXI_BRESP,
  input  logic         M_AXI_BVALID,
  output logic         M_AXI_BREADY,
  output logic [26:0]  M_AXI_ARADDR,
  output logic [7:0]   M_AXI_ARLEN,
  output logic [2:0]   M_AXI_ARSIZE,
  output logic [1:0]   M_AXI_ARBURST,
  output logic [1:0]   M_AXI_ARLOCK,
  output logic [3:0]   M_AXI_ARCACHE,
  output logic [2:0]   M_AXI_ARPROT,
  output logic [3:0]   M_AXI_ARQOS,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic [127:0] M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RLAST,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY
);

  // Single beat of 16 bytes, incrementing burst, bufferable/modifiable.
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b100;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_WSTRB   = 16'hFFFF;
  assign M_AXI_WLAST   = M_AXI_WVALID;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b100;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'd0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;

  // Response codes are not acted on; the cache has no error path.
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BRESP, M_AXI_RRESP};

  // ---------------- write engine ----------------
`ifdef AXI_AW_W_CONCURRENT_EN
  typedef enum logic [1:0] {W_IDLE, W_AW_W, W_RESP} w_state_t;
`else
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
`endif
  w_state_t w_state;

  assign wr_ready = (w_state == W_IDLE);

`ifdef AXI_AW_W_CONCURRENT_EN
  // A channel is still pending if its VALID is up and does not fire this cycle.
  logic aw_pend, w_pend;
  assign aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
  assign w_pend  = M_AXI_WVALID  && !M_AXI_WREADY;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wr_valid) begin
          M_AXI_AWADDR  <= wr_addr;
          M_AXI_WDATA   <= wr_data;
          M_AXI_AWVALID <= 1'b1;
`ifdef AXI_AW_W_CONCURRENT_EN
          M_AXI_WVALID  <= 1'b1;
          w_state       <= W_AW_W;
`else
          w_state       <= W_ADDR;
`endif
        end
`ifdef AXI_AW_W_CONCURRENT_EN
        W_AW_W: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            M_AXI_BREADY <= 1'b1;
            w_state      <= W_RESP;
          end
        end
`else
        W_ADDR: if (M_AXI_AWREADY) begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (M_AXI_WREADY) begin
          M_AXI_WVALID <= 1'b0;
          M_AXI_BREADY <= 1'b1;
          w_state      <= W_RESP;
        end
`endif
        W_RESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} r_state_t;
  r_state_t r_state;

  assign rd_aready = (r_state == R_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (rd_avalid) begin
          M_AXI_ARADDR  <= rd_addr;
          M_AXI_ARVALID <= 1'b1;
          r_state       <= R_ADDR;
        end
        R_ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b1;
          r_state       <= R_DATA;
        end
        // rd_valid comes only from a captured beat, so an early rd_dready
        // from the consumer cannot complete the read prematurely.
        R_DATA: if (M_AXI_RVALID && M_AXI_RLAST) begin
          rd_data      <= M_AXI_RDATA;
          rd_valid     <= 1'b1;
          M_AXI_RREADY <= 1'b0;
          r_state      <= R_HOLD;
        end
        R_HOLD: if (rd_dready) begin
          rd_valid <= 1'b0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_master.sv
// tb_ddr_axi_master
//   Self-checking bench for ddr_axi_master. A behavioural AXI slave with
//   programmable per-channel ready/response delays answers the DUT. Expected
//   addresses and data go into queues when requests are accepted, and are
//   popped when the matching handshake appears on the bus. Inputs and checks
//   happen on the falling edge; the slave acts 1 ns later.
module tb_ddr_axi_master;

  logic         clk = 1'b0;
  logic         rst;
  logic [26:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;
  logic         wr_valid, rd_avalid, rd_dready;
  logic         wr_ready, rd_aready, rd_valid;
  logic [127:0] rd_data;
  logic [26:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [7:0]   M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0]   M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0]   M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_ARLOCK;
  logic         M_AXI_AWLOCK;
  logic [3:0]   M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
  logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [127:0] M_AXI_WDATA;
  logic [15:0]  M_AXI_WSTRB;
  logic         M_AXI_WLAST;
  logic         M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic         M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_RLAST = 1'b0;
  logic [1:0]   M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [127:0] M_AXI_RDATA = '0;

  always #5 clk = ~clk;

  ddr_axi_master dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Cycles wr_ready stays low after acceptance, for the given slave delays.
  function automatic int wr_lat(input int a, input int w, input int b);
`ifdef AXI_AW_W_CONCURRENT_EN
    return 2 + ((a > w) ? a : w) + b;
`else
    return 3 + a + w + b;
`endif
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [26:0]  exp_aw[$];
  logic [127:0] exp_w[$];
  logic [26:0]  exp_ar[$];
  logic [127:0] exp_rd[$];

  // ---------------- slave configuration ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [127:0] r_payload = '0;
  int flush_req = 0;

  // ---------------- slave / monitor ----------------
  int cyc = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rd_hs = 0;
  int b_cyc = 0, r_cyc = 0;

  always begin : slave
    int aw_c, w_c, ar_c, b_c, r_c, flush_seen;
    bit aw_fire, w_fire, ar_fire, b_fire, r_fire, b_pend, r_pend;
    bit aw_wait, w_wait, ar_wait;
    logic [26:0]  aw_prev, ar_prev;
    logic [127:0] w_prev, r_beat;
    @(negedge clk);
    #1;
    cyc++;

    // B channel: response b_dly cycles after the W handshake
    if (b_fire) M_AXI_BVALID = 1'b0;
    if (b_pend) begin
      if (b_c >= b_dly) begin M_AXI_BVALID = 1'b1; b_pend = 0; end
      else b_c++;
    end
    b_fire = M_AXI_BVALID && (M_AXI_BREADY === 1'b1) && !rst;
    if (b_fire) begin b_hs++; b_cyc = cyc; end

    // R channel: beat r_dly cycles after the AR handshake
    if (r_fire || flush_seen != flush_req) begin
      M_AXI_RVALID = 1'b0;
      M_AXI_RLAST  = 1'b0;
    end
    if (flush_seen != flush_req) begin
      flush_seen = flush_req;
      r_pend = 0;
      exp_rd.delete();
    end
    if (r_pend) begin
      if (r_c >= r_dly) begin
        M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = r_beat; r_pend = 0;
      end else r_c++;
    end
    r_fire = M_AXI_RVALID && (M_AXI_RREADY === 1'b1) && !rst;
    if (r_fire) begin r_hs++; r_cyc = cyc; exp_rd.push_back(M_AXI_RDATA); end

    // Upstream read data: never before its beat, and must match it
    if (rd_valid === 1'b1) chk("rd_valid_after_beat", 128'(exp_rd.size() > 0), 128'd1);
    if (rd_valid === 1'b1 && rd_dready && !rst) begin
      rd_hs++;
      if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
    end

    // AW channel
    if (aw_wait) begin
      chk("aw_valid_stable", 128'(M_AXI_AWVALID), 128'd1);
      chk("aw_addr_stable", 128'(M_AXI_AWADDR), 128'(aw_prev));
    end
    if (M_AXI_AWVALID === 1'b1 && !rst) begin
      if (aw_c >= aw_dly) M_AXI_AWREADY = 1'b1;
      else begin M_AXI_AWREADY = 1'b0; aw_c++; end
    end else begin M_AXI_AWREADY = 1'b0; aw_c = 0; end
    aw_fire = (M_AXI_AWVALID === 1'b1) && M_AXI_AWREADY && !rst;
    aw_wait = (M_AXI_AWVALID === 1'b1) && !aw_fire && !rst;
    aw_prev = M_AXI_AWADDR;
    if (aw_fire) begin
      aw_hs++; aw_c = 0;
      chk("awlen", 128'(M_AXI_AWLEN), 128'd0);
      chk("awsize", 128'(M_AXI_AWSIZE), 128'd4);
      chk("awburst_cache", 128'({M_AXI_AWBURST, M_AXI_AWCACHE}), 128'({2'b01, 4'b0011}));
      if (exp_aw.size() == 0) chk("aw_unexpected", 128'd1, 128'd0);
      else chk("awaddr", 128'(M_AXI_AWADDR), 128'(exp_aw.pop_front()));
    end

    // W channel
    if (w_wait) begin
      chk("w_valid_stable", 128'(M_AXI_WVALID), 128'd1);
      chk("w_data_stable", M_AXI_WDATA, w_prev);
    end
    if (M_AXI_WVALID === 1'b1 && !rst) begin
      if (w_c >= w_dly) M_AXI_WREADY = 1'b1;
      else begin M_AXI_WREADY = 1'b0; w_c++; end
    end else begin M_AXI_WREADY = 1'b0; w_c = 0; end
    w_fire = (M_AXI_WVALID === 1'b1) && M_AXI_WREADY && !rst;
    w_wait = (M_AXI_WVALID === 1'b1) && !w_fire && !rst;
    w_prev = M_AXI_WDATA;
    if (w_fire) begin
      w_hs++; w_c = 0; b_pend = 1; b_c = 0;
      chk("wstrb_wlast", 128'({M_AXI_WSTRB, M_AXI_WLAST}), 128'({16'hFFFF, 1'b1}));
      if (exp_w.size() == 0) chk("w_unexpected", 128'd1, 128'd0);
      else chk("wdata", M_AXI_WDATA, exp_w.pop_front());
    end

    // AR channel
    if (ar_wait) begin
      chk("ar_valid_stable", 128'(M_AXI_ARVALID), 128'd1);
      chk("ar_addr_stable", 128'(M_AXI_ARADDR), 128'(ar_prev));
    end
    if (M_AXI_ARVALID === 1'b1 && !rst) begin
      if (ar_c >= ar_dly) M_AXI_ARREADY = 1'b1;
      else begin M_AXI_ARREADY = 1'b0; ar_c++; end
    end else begin M_AXI_ARREADY = 1'b0; ar_c = 0; end
    ar_fire = (M_AXI_ARVALID === 1'b1) && M_AXI_ARREADY && !rst;
    ar_wait = (M_AXI_ARVALID === 1'b1) && !ar_fire && !rst;
    ar_prev = M_AXI_ARADDR;
    if (ar_fire) begin
      ar_hs++; ar_c = 0; r_pend = 1; r_c = 0; r_beat = r_payload;
      chk("arlen", 128'(M_AXI_ARLEN), 128'd0);
      chk("arsize", 128'(M_AXI_ARSIZE), 128'd4);
      chk("arburst_cache", 128'({M_AXI_ARBURST, M_AXI_ARCACHE}), 128'({2'b01, 4'b0011}));
      if (exp_ar.size() == 0) chk("ar_unexpected", 128'd1, 128'd0);
      else chk("araddr", 128'(M_AXI_ARADDR), 128'(exp_ar.pop_front()));
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic do_write(input logic [26:0] addr, input logic [127:0] data,
                          input int a, input int w, input int b, input int exp_low);
    int n, aw0, w0, b0;
    aw_dly = a; w_dly = w; b_dly = b;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    chk("wr_ready_idle", 128'(wr_ready), 128'd1);
    wr_addr = addr; wr_data = data; wr_valid = 1'b1;
    exp_aw.push_back(addr);
    exp_w.push_back(data);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_addr = 27'($urandom);
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("wr_ready_low_cycles", 128'(n), 128'(exp_low));
    chk("aw_handshakes", 128'(aw_hs - aw0), 128'd1);
    chk("w_handshakes", 128'(w_hs - w0), 128'd1);
    chk("b_before_wr_ready", 128'(b_hs - b0), 128'd1);
  endtask

  task automatic do_read(input logic [26:0] addr, input logic [127:0] data,
                         input int a, input int r, input int hold);
    int n;
    ar_dly = a; r_dly = r; r_payload = data;
    chk("rd_aready_idle", 128'(rd_aready), 128'd1);
    rd_addr = addr; rd_avalid = 1'b1; rd_dready = (hold == 0);
    exp_ar.push_back(addr);
    @(negedge clk);
    rd_avalid = 1'b0;
    rd_addr = 27'($urandom);
    n = 0;
    while (rd_valid !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("rd_latency", 128'(n), 128'(2 + a + r));
    for (int h = 0; h < hold; h++) begin
      chk("hold_rd_valid", 128'(rd_valid), 128'd1);
      chk("hold_rd_data", rd_data, data);
      chk("hold_rready", 128'(M_AXI_RREADY), 128'd0);
      chk("hold_rd_aready", 128'(rd_aready), 128'd0);
      @(negedge clk);
    end
    rd_dready = 1'b1;
    chk("rd_valid_final", 128'(rd_valid), 128'd1);
    chk("rd_data_final", rd_data, data);
    @(negedge clk);
    chk("rd_valid_drop", 128'(rd_valid), 128'd0);
    chk("rd_aready_return", 128'(rd_aready), 128'd1);
    chk("rd_data_kept", rd_data, data);
  endtask

  typedef struct {
    logic [26:0]  addr;
    logic [127:0] data;
    int a, w, b;
    int exp_low;
  } wvec_t;

  typedef struct {
    logic [26:0]  addr;
    logic [127:0] data;
    int a, r, hold;
  } rvec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    wvec_t wv[3];
    rvec_t rv[3];
    int n, r0, rdh0, pr;

    wv[0] = '{27'h0001230, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01, 0, 0, 3, wr_lat(0, 0, 3)};
    wv[1] = '{27'h5A5A5A0, 128'h11112222_33334444_55556666_77778888, 5, 2, 0, wr_lat(5, 2, 0)};
    wv[2] = '{27'h7FFFFF0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1, 3, 1, wr_lat(1, 3, 1)};
    rv[0] = '{27'h7FFFFF0, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 2, 0, 0};
    rv[1] = '{27'h0000010, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 0, 1, 4};
    rv[2] = '{27'h0000000, 128'h00000000_00000001_80000000_00000000, 3, 4, 1};

    rst = 1'b1; wr_valid = 1'b0; rd_avalid = 1'b0; rd_dready = 1'b0;
    wr_addr = 27'h1111110; wr_data = '1; rd_addr = 27'h2222220;
    // Requests during reset must be ignored
    @(negedge clk);
    wr_valid = 1'b1; rd_avalid = 1'b1;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0; rd_avalid = 1'b0;
    chk("rst_wr_ready", 128'(wr_ready), 128'd1);
    chk("rst_rd_aready", 128'(rd_aready), 128'd1);
    chk("rst_valids", 128'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 128'd0);
    chk("rst_readys", 128'({M_AXI_BREADY, M_AXI_RREADY}), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    chk("rst_latches", 128'({M_AXI_AWADDR, M_AXI_ARADDR}), 128'd0);
    chk("rst_wdata", M_AXI_WDATA, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 128'({M_AXI_AWVALID, M_AXI_ARVALID, wr_ready, rd_aready}), 128'b0011);

    for (int i = 0; i < 3; i++)
      do_write(wv[i].addr, wv[i].data, wv[i].a, wv[i].w, wv[i].b, wv[i].exp_low);
    for (int i = 0; i < 3; i++)
      do_read(rv[i].addr, rv[i].data, rv[i].a, rv[i].r, rv[i].hold);

    // Parallel read and write; delays chosen so B and R land on one edge
    pr = wr_lat(0, 0, 2) - 2;
    fork
      do_write(27'h0C0FFE0, 128'hFEEDFACE_0BADF00D_DEADC0DE_8BADF00D, 0, 0, 2, wr_lat(0, 0, 2));
      do_read(27'h0C0FFE0, 128'h13579BDF_2468ACE0_FDB97531_0ECA8642, 0, pr, 0);
    join
    chk("b_r_same_cycle", 128'(b_cyc), 128'(r_cyc));

    // Reset while waiting for the R beat; the late beat must be ignored
    ar_dly = 0; r_dly = 10; r_payload = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    rd_addr = 27'h0ABCDE0; rd_avalid = 1'b1; rd_dready = 1'b1;
    exp_ar.push_back(27'h0ABCDE0);
    @(negedge clk);
    rd_avalid = 1'b0;
    n = 0;
    while (M_AXI_RREADY !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    chk("mid_read_in_r_data", 128'(M_AXI_RREADY), 128'd1);
    r0 = r_hs; rdh0 = rd_hs;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_arvalid_rready", 128'({M_AXI_ARVALID, M_AXI_RREADY}), 128'd0);
    chk("mrst_rd_valid", 128'(rd_valid), 128'd0);
    chk("mrst_idle", 128'({rd_aready, wr_ready}), 128'b11);
    repeat (15) begin
      @(negedge clk);
      chk("late_beat_ignored", 128'({rd_valid, M_AXI_RREADY}), 128'd0);
    end
    chk("late_beat_no_handshake", 128'(r_hs - r0), 128'd0);
    chk("late_beat_no_delivery", 128'(rd_hs - rdh0), 128'd0);
    flush_req++;
    repeat (2) @(negedge clk);

    // Engine still works after the mid-flight reset
    do_read(27'h0123450, 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00, 1, 1, 0);

    chk("exp_aw_drained", 128'(exp_aw.size()), 128'd0);
    chk("exp_w_drained", 128'(exp_w.size()), 128'd0);
    chk("exp_ar_drained", 128'(exp_ar.size()), 128'd0);
    chk("exp_rd_drained", 128'(exp_rd.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
